// File: rtl/dca_matrix_register_stream_pkg.sv
// Shared types for the DCA matrix register family: stream FSM encoding and row-width helper.
package dca_matrix_register_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_t;

  function automatic int row_bits(input int num_col, input int bw_scalar);
    return num_col * bw_scalar;
  endfunction

endpackage

// File: rtl/dca_matrix_register_stream_if.sv
// Row-stream port bundle between the tensor DMA (master) and the matrix register (slave).
interface dca_matrix_register_stream_if #(
  parameter int BW_ROW = 256
);
  // A beat transfers on any rising edge where valid && ready; valid never waits on ready,
  // and data is stable whenever valid is high.
  logic              load_valid;
  logic              load_ready;
  logic [BW_ROW-1:0] load_data;
  logic              drain_valid;
  logic              drain_ready;
  logic [BW_ROW-1:0] drain_data;

  modport master (
    output load_valid, load_data, drain_ready,
    input  load_ready, drain_valid, drain_data
  );

  modport slave (
    input  load_valid, load_data, drain_ready,
    output load_ready, drain_valid, drain_data
  );
endinterface

// File: rtl/dca_matrix_register_stream_ctrl.sv
// Row-stream controller: IDLE/LOAD/DRAIN FSM, row counter, handshakes and the done pulse.
module dca_matrix_stream_ctrl
  import dca_matrix_register_stream_pkg::*;
#(
  parameter  int NUM_ROW = 8,
  localparam int CW      = $clog2(NUM_ROW)
) (
  input  logic          clk,
  input  logic          rstnn,
  input  logic          init,
  input  logic          load_start,
  input  logic          drain_start,
  input  logic          load_valid,
  input  logic          drain_ready,
  output logic          load_ready,
  output logic          drain_valid,
  output logic          busy,
  output logic          done,
  output logic          load_we,
  output logic [CW-1:0] row_idx,
  output stream_state_t state_dbg
);

  stream_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_done, w_done_nxt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(NUM_ROW - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    load_ready  = 1'b0;
    drain_valid = 1'b0;
    load_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (load_start)       w_state_nxt = ST_LOAD;
        else if (drain_start) w_state_nxt = ST_DRAIN;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load_we = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        drain_valid = 1'b1;
        if (drain_ready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // init aborts a stream silently: no done pulse for a cut-short transfer
    if (init) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign row_idx   = r_cnt;
  assign state_dbg = r_state;

endmodule

// File: rtl/dca_matrix_register_stream.sv
// NUM_ROW x NUM_COL matrix register with bulk/shift/transpose ops and row-stream load/drain.
// Build option DCA_MATRIX_REGISTER_STREAM_ROTATE_EN: unfilled shifts wrap instead of filling INIT_VALUE.
module dca_matrix_register_stream
  import dca_matrix_register_stream_pkg::*;
#(
  parameter  int                          NUM_ROW          = 8,
  parameter  int                          NUM_COL          = 8,
  parameter  int                          BW_TENSOR_SCALAR = 32,
  parameter  logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE      = '0,
  parameter  logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE       = RESET_VALUE,
  localparam int                          BW_ROW           = row_bits(NUM_COL, BW_TENSOR_SCALAR)
) (
  input  logic                                 clk,
  input  logic                                 rstnn,
  input  logic                                 init,
  input  logic                                 all_wenable,
  input  logic [NUM_ROW*BW_ROW-1:0]            all_wdata_list2d,
  input  logic                                 shift_up,
  input  logic                                 shift_left,
  input  logic                                 transpose,
  input  logic                                 downmost_wenable,
  input  logic [BW_ROW-1:0]                    downmost_wdata_list1d,
  input  logic                                 rightmost_wenable,
  input  logic [NUM_ROW*BW_TENSOR_SCALAR-1:0]  rightmost_wdata_list1d,
  input  logic                                 load_start,
  input  logic                                 drain_start,
  dca_matrix_register_stream_if.slave          stream,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_ROW*BW_ROW-1:0]            all_rdata_list2d,
  output logic [BW_ROW-1:0]                    upmost_rdata_list1d,
  output stream_state_t                        state_dbg
);

  localparam int BW = BW_TENSOR_SCALAR;
  typedef logic [NUM_ROW-1:0][NUM_COL-1:0][BW-1:0] mat_t;
  typedef logic [NUM_COL-1:0][BW-1:0]              row_t;

  mat_t                        r_mat, w_mat_nxt, w_up, w_left, w_tr;
  row_t                        w_up_fill;
  logic [NUM_ROW-1:0][BW-1:0]  w_left_fill;
  logic [NUM_ROW-1:0][BW-1:0]  w_rcol;
  logic                        w_load_we;
  logic [$clog2(NUM_ROW)-1:0]  w_row_idx;

  dca_matrix_stream_ctrl #(.NUM_ROW(NUM_ROW)) u_ctrl (
    .clk         (clk),
    .rstnn       (rstnn),
    .init        (init),
    .load_start  (load_start),
    .drain_start (drain_start),
    .load_valid  (stream.load_valid),
    .drain_ready (stream.drain_ready),
    .load_ready  (stream.load_ready),
    .drain_valid (stream.drain_valid),
    .busy        (busy),
    .done        (done),
    .load_we     (w_load_we),
    .row_idx     (w_row_idx),
    .state_dbg   (state_dbg)
  );

  assign w_rcol = rightmost_wdata_list1d;

  always_comb begin
    w_left_fill = '0;
    for (int r = 0; r < NUM_ROW; r++) begin
`ifdef DCA_MATRIX_REGISTER_STREAM_ROTATE_EN
      w_left_fill[r] = rightmost_wenable ? w_rcol[r] : r_mat[r][0];
`else
      w_left_fill[r] = rightmost_wenable ? w_rcol[r] : INIT_VALUE;
`endif
    end
`ifdef DCA_MATRIX_REGISTER_STREAM_ROTATE_EN
    w_up_fill = downmost_wenable ? row_t'(downmost_wdata_list1d) : r_mat[0];
`else
    w_up_fill = downmost_wenable ? row_t'(downmost_wdata_list1d) : {NUM_COL{INIT_VALUE}};
`endif
  end

  always_comb begin
    w_up   = r_mat;
    w_left = r_mat;
    for (int r = 0; r < NUM_ROW - 1; r++) w_up[r] = r_mat[r+1];
    w_up[NUM_ROW-1] = w_up_fill;
    for (int r = 0; r < NUM_ROW; r++) begin
      for (int c = 0; c < NUM_COL - 1; c++) w_left[r][c] = r_mat[r][c+1];
      w_left[r][NUM_COL-1] = w_left_fill[r];
    end
  end

  // Transpose exists only for square arrays; a non-square array keeps its contents.
  if (NUM_ROW == NUM_COL) begin : g_tr
    always_comb begin
      w_tr = r_mat;
      for (int r = 0; r < NUM_ROW; r++)
        for (int c = 0; c < NUM_COL; c++) w_tr[r][c] = r_mat[c][r];
    end
  end else begin : g_no_tr
    assign w_tr = r_mat;
  end

  always_comb begin
    w_mat_nxt = r_mat;
    if (init)                 w_mat_nxt = {(NUM_ROW*NUM_COL){INIT_VALUE}};
    else if (w_load_we)       w_mat_nxt[w_row_idx] = stream.load_data;
    else if (!busy) begin
      if (all_wenable)        w_mat_nxt = all_wdata_list2d;
      else if (shift_up)      w_mat_nxt = w_up;
      else if (shift_left)    w_mat_nxt = w_left;
      else if (transpose)     w_mat_nxt = w_tr;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) r_mat <= {(NUM_ROW*NUM_COL){RESET_VALUE}};
    else        r_mat <= w_mat_nxt;
  end

  assign all_rdata_list2d    = r_mat;
  assign upmost_rdata_list1d = r_mat[0];
  assign stream.drain_data   = r_mat[w_row_idx];

endmodule

// File: tb/tb_dca_matrix_register_stream.sv
// Directed + randomized bench for dca_matrix_register_stream: a 4x4 instance and a 4x8 instance.
module tb_dca_matrix_register_stream;
  import dca_matrix_register_stream_pkg::*;

  localparam int          BW    = 16;
  localparam logic [15:0] INITV = 16'h00F0;
  localparam int          AR = 4, AC = 4, BR = 4, BC = 8;
`ifdef DCA_MATRIX_REGISTER_STREAM_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic                  a_init, a_wen, a_su, a_sl, a_tr, a_dwen, a_rwen, a_ls, a_ds;
  logic [AR*AC*BW-1:0]   a_wdata, a_rdata;
  logic [AC*BW-1:0]      a_ddata, a_up;
  logic [AR*BW-1:0]      a_rcol;
  logic                  a_busy, a_done;
  stream_state_t         a_st;
  dca_matrix_register_stream_if #(.BW_ROW(AC*BW)) a_if();

  logic                  b_init, b_wen, b_su, b_sl, b_tr, b_dwen, b_rwen, b_ls, b_ds;
  logic [BR*BC*BW-1:0]   b_wdata, b_rdata;
  logic [BC*BW-1:0]      b_ddata, b_up;
  logic [BR*BW-1:0]      b_rcol;
  logic                  b_busy, b_done;
  stream_state_t         b_st;
  dca_matrix_register_stream_if #(.BW_ROW(BC*BW)) b_if();

  dca_matrix_register_stream #(
    .NUM_ROW(AR), .NUM_COL(AC), .BW_TENSOR_SCALAR(BW), .RESET_VALUE(16'h0), .INIT_VALUE(INITV)
  ) u_dut_a (
    .clk(clk), .rstnn(rstnn), .init(a_init), .all_wenable(a_wen), .all_wdata_list2d(a_wdata),
    .shift_up(a_su), .shift_left(a_sl), .transpose(a_tr),
    .downmost_wenable(a_dwen), .downmost_wdata_list1d(a_ddata),
    .rightmost_wenable(a_rwen), .rightmost_wdata_list1d(a_rcol),
    .load_start(a_ls), .drain_start(a_ds), .stream(a_if.slave),
    .busy(a_busy), .done(a_done), .all_rdata_list2d(a_rdata), .upmost_rdata_list1d(a_up),
    .state_dbg(a_st)
  );

  dca_matrix_register_stream #(
    .NUM_ROW(BR), .NUM_COL(BC), .BW_TENSOR_SCALAR(BW), .RESET_VALUE(16'h0), .INIT_VALUE(INITV)
  ) u_dut_b (
    .clk(clk), .rstnn(rstnn), .init(b_init), .all_wenable(b_wen), .all_wdata_list2d(b_wdata),
    .shift_up(b_su), .shift_left(b_sl), .transpose(b_tr),
    .downmost_wenable(b_dwen), .downmost_wdata_list1d(b_ddata),
    .rightmost_wenable(b_rwen), .rightmost_wdata_list1d(b_rcol),
    .load_start(b_ls), .drain_start(b_ds), .stream(b_if.slave),
    .busy(b_busy), .done(b_done), .all_rdata_list2d(b_rdata), .upmost_rdata_list1d(b_up),
    .state_dbg(b_st)
  );

  // Reference contents of both arrays, indexed [row][col].
  logic [15:0] ma[AR][AC];
  logic [15:0] mb[BR][BC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AR*AC*BW-1:0] flat_a();
    logic [AR*AC*BW-1:0] v;
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < AC; c++) v[(r*AC+c)*BW +: BW] = ma[r][c];
    return v;
  endfunction

  function automatic logic [BR*BC*BW-1:0] flat_b();
    logic [BR*BC*BW-1:0] v;
    for (int r = 0; r < BR; r++)
      for (int c = 0; c < BC; c++) v[(r*BC+c)*BW +: BW] = mb[r][c];
    return v;
  endfunction

  function automatic logic [AC*BW-1:0] row_a(input int r);
    logic [AC*BW-1:0] v;
    for (int c = 0; c < AC; c++) v[c*BW +: BW] = ma[r][c];
    return v;
  endfunction

  task automatic clear_ops();
    {a_init, a_wen, a_su, a_sl, a_tr, a_dwen, a_rwen, a_ls, a_ds} = '0;
    {b_init, b_wen, b_su, b_sl, b_tr, b_dwen, b_rwen, b_ls, b_ds} = '0;
  endtask

  task automatic rand_a_data();
    for (int k = 0; k < AR*AC*BW/32; k++) a_wdata[k*32 +: 32] = $urandom;
    a_ddata = {$urandom, $urandom};
    a_rcol  = {$urandom, $urandom};
  endtask

  // One idle-cycle array op on the 4x4 model, highest-priority request wins.
  task automatic model_a_edge();
    logic [15:0] t[AR][AC];
    t = ma;
    if (a_init) begin
      foreach (ma[r, c]) ma[r][c] = INITV;
    end else if (a_wen) begin
      foreach (ma[r, c]) ma[r][c] = a_wdata[(r*AC+c)*BW +: BW];
    end else if (a_su) begin
      foreach (ma[r, c])
        if (r < AR-1)    ma[r][c] = t[r+1][c];
        else if (a_dwen) ma[r][c] = a_ddata[c*BW +: BW];
        else             ma[r][c] = ROT ? t[0][c] : INITV;
    end else if (a_sl) begin
      foreach (ma[r, c])
        if (c < AC-1)    ma[r][c] = t[r][c+1];
        else if (a_rwen) ma[r][c] = a_rcol[r*BW +: BW];
        else             ma[r][c] = ROT ? t[r][0] : INITV;
    end else if (a_tr) begin
      foreach (ma[r, c]) ma[r][c] = t[c][r];
    end
  endtask

  task automatic do_op_a(input string tag);
    model_a_edge();
    tick();
    clear_ops();
    chk(tag, 512'(a_rdata), 512'(flat_a()));
    chk({tag, "_up"}, 512'(a_up), 512'(row_a(0)));
  endtask

  initial begin
    int idx, cyc;
    logic rdy;
    clear_ops();
    a_wdata = '0; a_ddata = '0; a_rcol = '0;
    b_wdata = '0; b_ddata = '0; b_rcol = '0;
    a_if.load_valid = 1'b0; a_if.load_data = '0; a_if.drain_ready = 1'b0;
    b_if.load_valid = 1'b0; b_if.load_data = '0; b_if.drain_ready = 1'b0;
    foreach (ma[r, c]) ma[r][c] = 16'h0;
    foreach (mb[r, c]) mb[r][c] = 16'h0;

    // reset state
    repeat (2) tick();
    chk("rst_all_a", 512'(a_rdata), 512'(flat_a()));
    chk("rst_all_b", 512'(b_rdata), 512'(flat_b()));
    chk("rst_load_ready", 512'(a_if.load_ready), 512'(1'b0));
    chk("rst_drain_valid", 512'(a_if.drain_valid), 512'(1'b0));
    chk("rst_busy", 512'(a_busy), 512'(1'b0));
    chk("rst_done", 512'(a_done), 512'(1'b0));
    rstnn = 1'b1;
    tick();

    // row-stream load with random gaps
    a_ls = 1'b1;
    tick();
    a_ls = 1'b0;
    chk("load_ready", 512'(a_if.load_ready), 512'(1'b1));
    chk("load_busy", 512'(a_busy), 512'(1'b1));
    for (int i = 0; i < AR; i++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("load_gap_done", 512'(a_done), 512'(1'b0));
      end
      a_if.load_valid = 1'b1;
      a_if.load_data  = {$urandom, $urandom};
      for (int c = 0; c < AC; c++) ma[i][c] = a_if.load_data[c*BW +: BW];
      tick();
      a_if.load_valid = 1'b0;
      chk("load_rows", 512'(a_rdata), 512'(flat_a()));
      chk("load_done", 512'(a_done), 512'(i == AR-1));
      chk("load_busy_after", 512'(a_busy), 512'(i != AR-1));
    end
    tick();
    chk("load_done_once", 512'(a_done), 512'(1'b0));

    // row-stream drain with drain_ready toggling
    a_ds = 1'b1;
    tick();
    a_ds = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < AR && cyc < 40) begin
      chk("drain_valid", 512'(a_if.drain_valid), 512'(1'b1));
      chk("drain_data", 512'(a_if.drain_data), 512'(row_a(idx)));
      chk("drain_done_early", 512'(a_done), 512'(1'b0));
      rdy = (cyc % 2 == 0);
      a_if.drain_ready = rdy;
      tick();
      a_if.drain_ready = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    chk("drain_complete", 512'(idx), 512'(AR));
    chk("drain_done", 512'(a_done), 512'(1'b1));
    chk("drain_valid_off", 512'(a_if.drain_valid), 512'(1'b0));
    chk("drain_busy_off", 512'(a_busy), 512'(1'b0));

    // bulk write mat[r][c] = 4r+c, then shifts
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < AC; c++) a_wdata[(r*AC+c)*BW +: BW] = 16'(4*r + c);
    a_wen = 1'b1;
    do_op_a("bulk_4r_c");
    a_su = 1'b1; a_dwen = 1'b1; a_ddata = {AC{16'h00AA}};
    do_op_a("shift_up_fill");
    chk("shift_up_row3", 512'(a_rdata[3*AC*BW +: AC*BW]), 512'({AC{16'h00AA}}));
    a_su = 1'b1;
    do_op_a("shift_up_nofill");
    rand_a_data();
    a_sl = 1'b1; a_rwen = 1'b1;
    do_op_a("shift_left_fill");
    a_sl = 1'b1;
    do_op_a("shift_left_nofill");

    // op priority
    rand_a_data();
    a_su = 1'b1; a_sl = 1'b1; a_tr = 1'b1;
    do_op_a("prio_up_over_left_tr");
    a_sl = 1'b1; a_tr = 1'b1;
    do_op_a("prio_left_over_tr");
    rand_a_data();
    a_wen = 1'b1; a_su = 1'b1;
    do_op_a("prio_wen_over_up");
    a_init = 1'b1; a_wen = 1'b1;
    do_op_a("prio_init_over_wen");

    // square transpose of 4r+c
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < AC; c++) a_wdata[(r*AC+c)*BW +: BW] = 16'(4*r + c);
    a_wen = 1'b1;
    do_op_a("bulk_4r_c_again");
    a_tr = 1'b1;
    do_op_a("transpose_sq");
    chk("transpose_elem_1_2", 512'(a_rdata[(1*AC+2)*BW +: BW]), 512'(16'd9));

    // randomized op mix while idle
    for (int n = 0; n < 40; n++) begin
      rand_a_data();
      a_init = ($urandom_range(0, 15) == 0);
      a_wen  = ($urandom_range(0, 3) == 0);
      a_su   = ($urandom_range(0, 2) == 0);
      a_sl   = ($urandom_range(0, 2) == 0);
      a_tr   = ($urandom_range(0, 2) == 0);
      a_dwen = $urandom_range(0, 1);
      a_rwen = $urandom_range(0, 1);
      do_op_a("rand_op");
    end

    // non-square instance: transpose is a no-op, shift_left fills or wraps
    for (int k = 0; k < BR*BC*BW/32; k++) b_wdata[k*32 +: 32] = $urandom;
    foreach (mb[r, c]) mb[r][c] = b_wdata[(r*BC+c)*BW +: BW];
    b_wen = 1'b1;
    tick();
    clear_ops();
    chk("b_bulk", 512'(b_rdata), 512'(flat_b()));
    b_tr = 1'b1;
    tick();
    clear_ops();
    chk("b_transpose_noop", 512'(b_rdata), 512'(flat_b()));
    b_sl = 1'b1;
    for (int r = 0; r < BR; r++) begin
      logic [15:0] first;
      first = mb[r][0];
      for (int c = 0; c < BC-1; c++) mb[r][c] = mb[r][c+1];
      mb[r][BC-1] = ROT ? first : INITV;
    end
    tick();
    clear_ops();
    chk("b_shift_left_nofill", 512'(b_rdata), 512'(flat_b()));

    // init in the middle of a load: clear, back to idle, no done
    a_ls = 1'b1;
    tick();
    a_ls = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_if.load_valid = 1'b1;
      a_if.load_data  = {$urandom, $urandom};
      tick();
    end
    a_init = 1'b1;
    a_if.load_data = {$urandom, $urandom};
    foreach (ma[r, c]) ma[r][c] = INITV;
    tick();
    clear_ops();
    a_if.load_valid = 1'b0;
    chk("init_abort_all", 512'(a_rdata), 512'(flat_a()));
    chk("init_abort_busy", 512'(a_busy), 512'(1'b0));
    chk("init_abort_done", 512'(a_done), 512'(1'b0));
    tick();
    chk("init_abort_done_late", 512'(a_done), 512'(1'b0));

    // array ops and start pulses are ignored during a drain
    rand_a_data();
    a_wen = 1'b1;
    do_op_a("pre_drain_bulk");
    a_ds = 1'b1;
    tick();
    a_ds = 1'b0;
    a_su = 1'b1; a_dwen = 1'b1; a_ls = 1'b1;
    tick();
    clear_ops();
    chk("busy_shift_ignored", 512'(a_rdata), 512'(flat_a()));
    chk("busy_still_drain", 512'(a_if.drain_valid), 512'(1'b1));
    chk("busy_start_ignored", 512'(a_if.load_ready), 512'(1'b0));
    for (int i = 0; i < AR; i++) begin
      chk("drain2_data", 512'(a_if.drain_data), 512'(row_a(i)));
      a_if.drain_ready = 1'b1;
      tick();
    end
    a_if.drain_ready = 1'b0;
    chk("drain2_done", 512'(a_done), 512'(1'b1));

    // simultaneous starts: load wins; then init aborts it
    a_ls = 1'b1; a_ds = 1'b1;
    tick();
    clear_ops();
    chk("both_start_load", 512'(a_if.load_ready), 512'(1'b1));
    chk("both_start_no_drain", 512'(a_if.drain_valid), 512'(1'b0));
    a_init = 1'b1;
    foreach (ma[r, c]) ma[r][c] = INITV;
    tick();
    clear_ops();
    chk("final_init_busy", 512'(a_busy), 512'(1'b0));
    chk("final_init_all", 512'(a_rdata), 512'(flat_a()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
